// File: rtl/sc_time_bcd_reader_pkg.sv
// sc_time_pkg: shared types and constants for the time-count BCD reader.
//   timeBcdState_t  : conversion FSM states (IDLE, SHIFT)
//   BCD_DIGIT_W     : width of one packed BCD digit
//   ADD3_THRESHOLD  : digit value at or above which double-dabble adds 3
//   cntWidth()      : bits needed for a shift counter that holds 0..dataWidth
package sc_time_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } timeBcdState_t;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam logic [3:0]  ADD3_THRESHOLD = 4'd5;

  function automatic int unsigned cntWidth(input int unsigned dataWidth);
    return $clog2(dataWidth + 1);
  endfunction

endpackage

// File: rtl/sc_bcd_add3.sv
// sc_bcd_add3: combinational double-dabble digit corrector.
//   digit     : 4-bit BCD scratch digit
//   corrected : digit + 3 when digit >= 5, otherwise digit unchanged
module sc_bcd_add3
  import sc_time_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  always_comb begin
    corrected = digit;
    if (digit >= ADD3_THRESHOLD) begin
      corrected = digit + 4'd3;
    end
  end

endmodule

// File: rtl/sc_time_bcd_reader.sv
// sc_time_bcd_reader: samples the binary time bus on START and converts it to
// packed BCD with a sequential shift-and-add-3 engine, one bit per clock.
//   SC_TimeBCD_CLOCK_50      : system clock, rising edge
//   SC_TimeBCD_RESET_InLow   : asynchronous active-low reset
//   SC_TimeBCD_START_InHigh  : sample SC_TimeBCD_data_InBUS this cycle
//   SC_TimeBCD_data_InBUS    : binary time value
//   SC_TimeBCD_bcd_OutBUS    : packed BCD result, units digit in [3:0]
//   SC_TimeBCD_BUSY_OutHigh  : conversion running or a request pending
//   SC_TimeBCD_DONE_OutHigh  : one-cycle pulse when the bcd bus updates
//   SC_TimeBCD_blank_OutBUS  : leading-zero blanking mask (only with
//                              SC_TIMEBCD_BLANK_EN defined)
module sc_time_bcd_reader
  import sc_time_pkg::*;
#(
  parameter int unsigned TimeBCD_DATAWIDTH = 8,
  parameter int unsigned TimeBCD_DIGITS    = 3
) (
  input  logic                                  SC_TimeBCD_CLOCK_50,
  input  logic                                  SC_TimeBCD_RESET_InLow,
  input  logic                                  SC_TimeBCD_START_InHigh,
  input  logic [TimeBCD_DATAWIDTH-1:0]          SC_TimeBCD_data_InBUS,
  output logic [BCD_DIGIT_W*TimeBCD_DIGITS-1:0] SC_TimeBCD_bcd_OutBUS,
  output logic                                  SC_TimeBCD_BUSY_OutHigh,
  output logic                                  SC_TimeBCD_DONE_OutHigh
`ifdef SC_TIMEBCD_BLANK_EN
  ,
  output logic [TimeBCD_DIGITS-1:0]             SC_TimeBCD_blank_OutBUS
`endif
);

  localparam int unsigned SCR_W = BCD_DIGIT_W * TimeBCD_DIGITS;
  localparam int unsigned CNT_W = cntWidth(TimeBCD_DATAWIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TimeBCD_DATAWIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  timeBcdState_t                state, stateNext;
  logic [CNT_W-1:0]             cnt, cntNext;
  logic [TimeBCD_DATAWIDTH-1:0] binReg, binNext, binShift;
  logic [SCR_W-1:0]             scratch, scratchNext, scratchAdj, scratchShift;
  logic                         pendFlag, pendFlagNext;
  logic [TimeBCD_DATAWIDTH-1:0] pendData, pendDataNext;
  logic [SCR_W-1:0]             bcdNext;
  logic                         busyNext, doneNext;

  for (genvar g = 0; g < TimeBCD_DIGITS; g++) begin : genAdd3
    sc_bcd_add3 uAdd3 (
      .digit     (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .corrected (scratchAdj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign scratchShift = {scratchAdj[SCR_W-2:0], binReg[TimeBCD_DATAWIDTH-1]};
  assign binShift     = {binReg[TimeBCD_DATAWIDTH-2:0], 1'b0};

`ifdef SC_TIMEBCD_BLANK_EN
  localparam logic [TimeBCD_DIGITS-1:0] BLANK_RST = {{(TimeBCD_DIGITS-1){1'b1}}, 1'b0};
  logic [TimeBCD_DIGITS-1:0] blankCalc, blankNext;
  logic                      allZero;

  // Walk from the most significant digit down; a digit blanks only while
  // every digit above it is also zero. The units digit is always shown.
  always_comb begin
    blankCalc = '0;
    allZero   = 1'b1;
    for (int unsigned k = 0; k < TimeBCD_DIGITS; k++) begin
      allZero = allZero &&
                (scratchShift[(TimeBCD_DIGITS-1-k)*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      blankCalc[TimeBCD_DIGITS-1-k] = allZero && (k != TimeBCD_DIGITS-1);
    end
  end
`endif

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    binNext      = binReg;
    scratchNext  = scratch;
    pendFlagNext = pendFlag;
    pendDataNext = pendData;
    bcdNext      = SC_TimeBCD_bcd_OutBUS;
    doneNext     = 1'b0;
`ifdef SC_TIMEBCD_BLANK_EN
    blankNext    = SC_TimeBCD_blank_OutBUS;
`endif
    case (state)
      IDLE: begin
        if (SC_TimeBCD_START_InHigh) begin
          binNext     = SC_TimeBCD_data_InBUS;
          scratchNext = '0;
          cntNext     = CNT_LOAD;
          stateNext   = SHIFT;
        end
      end
      SHIFT: begin
        binNext     = binShift;
        scratchNext = scratchShift;
        cntNext     = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          bcdNext  = scratchShift;
          doneNext = 1'b1;
`ifdef SC_TIMEBCD_BLANK_EN
          blankNext = blankCalc;
`endif
          // Pending request starts now; a START on this same edge then
          // becomes the new pending entry so it is not lost.
          if (pendFlag) begin
            binNext     = pendData;
            scratchNext = '0;
            cntNext     = CNT_LOAD;
            if (SC_TimeBCD_START_InHigh) begin
              pendDataNext = SC_TimeBCD_data_InBUS;
            end else begin
              pendFlagNext = 1'b0;
            end
          end else if (SC_TimeBCD_START_InHigh) begin
            binNext     = SC_TimeBCD_data_InBUS;
            scratchNext = '0;
            cntNext     = CNT_LOAD;
          end else begin
            stateNext = IDLE;
          end
        end else if (SC_TimeBCD_START_InHigh) begin
          pendDataNext = SC_TimeBCD_data_InBUS;
          pendFlagNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    busyNext = (stateNext == SHIFT) || pendFlagNext;
  end

  always_ff @(posedge SC_TimeBCD_CLOCK_50 or negedge SC_TimeBCD_RESET_InLow) begin
    if (!SC_TimeBCD_RESET_InLow) begin
      state                   <= IDLE;
      cnt                     <= '0;
      binReg                  <= '0;
      scratch                 <= '0;
      pendFlag                <= 1'b0;
      pendData                <= '0;
      SC_TimeBCD_bcd_OutBUS   <= '0;
      SC_TimeBCD_BUSY_OutHigh <= 1'b0;
      SC_TimeBCD_DONE_OutHigh <= 1'b0;
`ifdef SC_TIMEBCD_BLANK_EN
      SC_TimeBCD_blank_OutBUS <= BLANK_RST;
`endif
    end else begin
      state                   <= stateNext;
      cnt                     <= cntNext;
      binReg                  <= binNext;
      scratch                 <= scratchNext;
      pendFlag                <= pendFlagNext;
      pendData                <= pendDataNext;
      SC_TimeBCD_bcd_OutBUS   <= bcdNext;
      SC_TimeBCD_BUSY_OutHigh <= busyNext;
      SC_TimeBCD_DONE_OutHigh <= doneNext;
`ifdef SC_TIMEBCD_BLANK_EN
      SC_TimeBCD_blank_OutBUS <= blankNext;
`endif
    end
  end

endmodule

// File: tb/tb_sc_time_bcd_reader.sv
// tb_sc_time_bcd_reader: self-checking bench for sc_time_bcd_reader.
// Accepted requests are queued with their timing; completions pop the queue
// and the expected BCD is formed with decimal arithmetic.
module tb_sc_time_bcd_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned ND = 3;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] data = '0;
  logic [4*ND-1:0] bcd;
  logic          busy, done;
`ifdef SC_TIMEBCD_BLANK_EN
  logic [ND-1:0] blank;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [DW-1:0]   q[$];
  int unsigned     remaining = 0;
  logic [4*ND-1:0] lastBcd = '0;
  logic            doneExp = 1'b0;
  logic            busyExp = 1'b0;

  sc_time_bcd_reader #(
    .TimeBCD_DATAWIDTH (DW),
    .TimeBCD_DIGITS    (ND)
  ) dut (
    .SC_TimeBCD_CLOCK_50     (clk),
    .SC_TimeBCD_RESET_InLow  (rstN),
    .SC_TimeBCD_START_InHigh (start),
    .SC_TimeBCD_data_InBUS   (data),
    .SC_TimeBCD_bcd_OutBUS   (bcd),
    .SC_TimeBCD_BUSY_OutHigh (busy),
    .SC_TimeBCD_DONE_OutHigh (done)
`ifdef SC_TIMEBCD_BLANK_EN
    ,
    .SC_TimeBCD_blank_OutBUS (blank)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4*ND-1:0] toBcd(input logic [DW-1:0] v);
    int unsigned n;
    n = v;
    return 12'((n % 10) | (((n / 10) % 10) << 4) | ((n / 100) << 8));
  endfunction

  function automatic logic [ND-1:0] blankOf(input logic [4*ND-1:0] b);
    logic [ND-1:0] m;
    int unsigned   n;
    n = b;
    m = '0;
    if (((n >> 8) & 15) == 0) m[2] = 1'b1;
    if (((n >> 4) & 255) == 0) m[1] = 1'b1;
    return m;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkOutputs(input string phase);
    checkVal({phase, ".done"}, 32'(done), 32'(doneExp));
    checkVal({phase, ".busy"}, 32'(busy), 32'(busyExp));
    checkVal({phase, ".bcd"}, 32'(bcd), 32'(lastBcd));
`ifdef SC_TIMEBCD_BLANK_EN
    checkVal({phase, ".blank"}, 32'(blank), 32'(blankOf(lastBcd)));
`endif
  endtask

  // Drive one cycle of stimulus, advance the expectation, sample #1 later.
  task automatic step(input logic s, input logic [DW-1:0] d);
    start = s;
    data  = d;
    @(posedge clk);
    doneExp = 1'b0;
    if (remaining == 0) begin
      if (s) begin
        q.push_back(d);
        remaining = DW;
      end
    end else begin
      remaining--;
      if (remaining == 0) begin
        doneExp = 1'b1;
        lastBcd = toBcd(q.pop_front());
        if (s) q.push_back(d);
        if (q.size() > 0) remaining = DW;
      end else if (s) begin
        if (q.size() == 2) q[1] = d;
        else q.push_back(d);
      end
    end
    busyExp = (q.size() > 0);
    #1;
    checkOutputs("step");
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic asyncReset();
    rstN = 1'b0;
    q.delete();
    remaining = 0;
    lastBcd   = '0;
    doneExp   = 1'b0;
    busyExp   = 1'b0;
    #1;
    checkOutputs("reset");
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    #3;
    checkOutputs("por");
    @(negedge clk);
    rstN = 1'b1;
    idle(3);

    // Single conversion, DONE exactly DW edges after the start edge.
    step(1'b1, 8'd59);
    idle(12);

    // Extremes.
    step(1'b1, 8'd255);
    idle(10);
    step(1'b1, 8'd0);
    idle(10);

    // Requests while busy: 42 is overwritten by 99.
    step(1'b1, 8'd7);
    idle(2);
    step(1'b1, 8'd42);
    idle(1);
    step(1'b1, 8'd99);
    idle(20);

    // Reset mid-conversion.
    step(1'b1, 8'd200);
    idle(3);
    #2;
    asyncReset();
    step(1'b1, 8'd13);
    idle(12);

    // START held high: back-to-back conversions.
    for (int unsigned i = 0; i < 30; i++) step(1'b1, 8'd1);
    idle(20);

    // Random traffic.
    for (int unsigned i = 0; i < 200; i++) begin
      step(($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)));
    end
    idle(20);

    checkVal("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_time_bcd_reader.md
Name: sc_time_bcd_reader

Overview:
- Consumer at the far end of the free-running time-count register bus.
- Samples the binary time value on a start strobe and converts it to packed BCD digits with a sequential shift-and-add-3 (double-dabble) engine.
- Presents the digits to the 7-segment display path with a busy/done handshake.
- Sits between the time-count register and the display decoders.

Parameters:
- TimeBCD_DATAWIDTH, 8, width of the binary time bus being read.
- TimeBCD_DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^DATAWIDTH − 1.

Ports:
- SC_TimeBCD_CLOCK_50  input  1  system clock, rising edge.
- SC_TimeBCD_RESET_InLow  input  1  asynchronous reset, active-low.
- SC_TimeBCD_START_InHigh  input  1  request: sample data bus this cycle.
- SC_TimeBCD_data_InBUS  input  DATAWIDTH  binary time value.
- SC_TimeBCD_bcd_OutBUS  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- SC_TimeBCD_BUSY_OutHigh  output  1  conversion in progress or pending.
- SC_TimeBCD_DONE_OutHigh  output  1  one-cycle pulse; bcd bus just updated.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset (RESET_InLow=0), all outputs and state cleared:
  - bcd=0, BUSY=0, DONE=0.
  - FSM=IDLE, pending flag=0, shift counter=0.
- FSM states: IDLE, SHIFT.
- IDLE:
  - If START=1 at an edge: capture data into the shift register, clear the BCD scratch, load counter=DATAWIDTH, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each cycle:
  - For every scratch digit ≥5, add 3 (4-bit, no carry out).
  - Then shift {scratch, binary} left by 1 and decrement the counter.
  - The edge that performs the DATAWIDTH-th shift loads bcd_OutBUS with the final scratch, asserts DONE for exactly one cycle, and leaves SHIFT.
- Latency: START sampled at edge k → bcd valid and DONE=1 from edge k+DATAWIDTH (8 clocks default).
- bcd_OutBUS holds its last value between conversions. It never shows intermediate scratch values.
- BUSY=1 whenever state=SHIFT or the pending flag is set. BUSY is a registered output.
- START while in SHIFT:
  - Capture data into a one-deep pending register and set the pending flag.
  - A further START while pending overwrites the pending data (latest value wins).
  - START is never dropped silently.
- Completion with pending set, on the completing edge:
  - Load the pending value, reload counter=DATAWIDTH, clear pending, stay in SHIFT.
  - DONE still pulses for the finished conversion.
- Completion with START=1 on the completing edge (pending clear): treated as a pending hit. The START data starts immediately, same as above.
- Reset mid-conversion: everything clears immediately. No DONE is produced for the aborted value. bcd returns to 0.
- Width rules: scratch is 4*DIGITS bits, the counter is clog2(DATAWIDTH+1) bits, and digit overflow is impossible given the DIGITS constraint.

Optional Feature:
- Macro: SC_TIMEBCD_BLANK_EN.
- When defined:
  - Adds output SC_TimeBCD_blank_OutBUS [DIGITS-1:0], registered and updated on the same edge as bcd.
  - Bit i=1 when digit i and all higher digits are zero, except digit 0, whose blank bit is always 0.
  - Reset value: all ones except bit 0.
- When undefined: the port and its logic are absent, and the display shows leading zeros.

Decomposition:
- Package sc_time_pkg holds:
  - FSM state enum (IDLE, SHIFT).
  - BCD digit width constant (4).
  - Add-3 threshold constant (5).
  - Helper function computing the counter width.
- One natural sub-module: sc_bcd_add3, a combinational 4-bit digit corrector (in ≥5 → in+3). It is instantiated DIGITS times in a generate loop.

Test Plan:
- Reset low, then release, no START → bcd=12'h000, BUSY=0, DONE=0. With BLANK_EN, blank=3'b110.
- START with data=8'd59 → BUSY high the next cycle; DONE pulses exactly 8 clocks after the start edge; bcd=12'h059; BUSY=0 afterward.
- START data=8'd255, then data=8'd0 → bcd=12'h255, then 12'h000. With BLANK_EN, blank=3'b000, then 3'b110.
- START data=8'd7, then START data=8'd42 at cycle 3 and data=8'd99 at cycle 5 → DONE with 12'h007, then the next DONE 8 clocks later with 12'h099 (42 discarded); BUSY continuous throughout.
- START data=8'd200, assert RESET_InLow=0 at cycle 4 → immediate bcd=0, BUSY=0, no DONE; a new START of 8'd13 then yields 12'h013 normally.
- START held high continuously with data=8'd1 → back-to-back conversions; DONE every 8 clocks; bcd=12'h001; BUSY never drops.
